// File: rtl/smem_query_arbiter.sv
// Round-robin arbiter that shares the single read-RAM query port among NUM_REQ requesters.
// A tag pipe follows each query through the fixed RAM latency and returns the base to its issuer.
module smem_query_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int RAM_LAT = 3,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 hold,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [6*NUM_REQ-1:0] req_status,
  input  logic [7*NUM_REQ-1:0] req_position,
  input  logic [8*NUM_REQ-1:0] req_read_num,
  output logic [5:0]           ram_status_query,
  output logic [6:0]           ram_query_pos,
  output logic [7:0]           ram_query_rnum,
  input  logic [7:0]           ram_read_query,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_data,
  output logic [6:0]           rsp_position,
  output logic [7:0]           rsp_read_num,
  output logic [3:0]           inflight
);

  localparam logic [5:0] BUBBLE  = 6'b110000;
  localparam logic [5:0] F_BREAK = 6'h02;
  localparam logic [5:0] BCK_END = 6'h06;

  typedef struct packed {
    logic            valid;
    logic            nofetch;
    logic [ID_W-1:0] id;
    logic [6:0]      pos;
    logic [7:0]      rnum;
  } tag_t;

  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [5:0]         ram_status_q, ram_status_d;
  logic [6:0]         ram_pos_q, ram_pos_d;
  logic [7:0]         ram_rnum_q, ram_rnum_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [7:0]         rsp_data_q, rsp_data_d;
  logic [6:0]         rsp_pos_q, rsp_pos_d;
  logic [7:0]         rsp_rnum_q, rsp_rnum_d;
  logic [3:0]         inflight_q, inflight_d;
  tag_t               tag_q [RAM_LAT+1];
  tag_t               tag_in;
  tag_t               tag_out;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               found;
  logic               hs;
  int                 idx;
  int                 gsel;
  logic [5:0]         sel_status;
  logic [6:0]         sel_pos;
  logic [7:0]         sel_rnum;
  logic               sel_nofetch;

  // Rotating priority: search starts just past the last granted requester.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    if (!hold) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (int'(rr_ptr_q) + k) % NUM_REQ;
        if (!found && req_valid[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_id   = ID_W'(idx);
        end
      end
    end
  end

  assign req_ready = grant;
  assign hs        = found;
  assign tag_out   = tag_q[RAM_LAT];

  always_comb begin
    gsel        = int'(grant_id);
    sel_status  = req_status[6*gsel +: 6];
    sel_pos     = req_position[7*gsel +: 7];
    sel_rnum    = req_read_num[8*gsel +: 8];
    sel_nofetch = (sel_status == F_BREAK) || (sel_status == BCK_END) || (sel_status == BUBBLE);

    tag_in.valid   = hs;
    tag_in.nofetch = sel_nofetch;
    tag_in.id      = grant_id;
    tag_in.pos     = sel_pos;
    tag_in.rnum    = sel_rnum;

    rr_ptr_d     = hs ? grant_id : rr_ptr_q;
    ram_status_d = (hs && !sel_nofetch) ? sel_status : BUBBLE;
    ram_pos_d    = hs ? sel_pos : ram_pos_q;
    ram_rnum_d   = hs ? sel_rnum : ram_rnum_q;

    rsp_valid_d = '0;
    rsp_data_d  = 8'hFF;
    rsp_pos_d   = rsp_pos_q;
    rsp_rnum_d  = rsp_rnum_q;
    if (tag_out.valid) begin
      rsp_valid_d[tag_out.id] = 1'b1;
      rsp_data_d              = tag_out.nofetch ? 8'hFF : ram_read_query;
      rsp_pos_d               = tag_out.pos;
      rsp_rnum_d              = tag_out.rnum;
    end

    inflight_d = inflight_q + {3'b000, hs} - {3'b000, tag_out.valid};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr_q     <= ID_W'(NUM_REQ - 1);
      ram_status_q <= BUBBLE;
      ram_pos_q    <= '0;
      ram_rnum_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= 8'hFF;
      rsp_pos_q    <= '0;
      rsp_rnum_q   <= '0;
      inflight_q   <= '0;
      // NOTE: the tag pipe is reset, unlike a data RAM, so queries in flight at reset are dropped.
      for (int i = 0; i <= RAM_LAT; i++) tag_q[i] <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      ram_status_q <= ram_status_d;
      ram_pos_q    <= ram_pos_d;
      ram_rnum_q   <= ram_rnum_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_pos_q    <= rsp_pos_d;
      rsp_rnum_q   <= rsp_rnum_d;
      inflight_q   <= inflight_d;
      tag_q[0]     <= tag_in;
      for (int i = 1; i <= RAM_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign ram_status_query = ram_status_q;
  assign ram_query_pos    = ram_pos_q;
  assign ram_query_rnum   = ram_rnum_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_data         = rsp_data_q;
  assign rsp_position     = rsp_pos_q;
  assign rsp_read_num     = rsp_rnum_q;
  assign inflight         = inflight_q;

endmodule
